mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive LSU wins while fetch waits (range 1..15).
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 if_req_i  in  1  fetch request; held high until if_gnt_o.
REQ-005 if_addr_i  in  32  fetch word address; stable while if_req_i high.
REQ-006 if_gnt_o  out  1  fetch request accepted by memory.
REQ-007 if_rvalid_o  out  1  fetch read data valid, one-cycle pulse.
REQ-008 if_rdata_o  out  32  fetch read data.
REQ-009 ls_req_i  in  1  load/store request; held high until ls_gnt_o.
REQ-010 ls_we_i  in  1  1 = store, 0 = load.
REQ-011 ls_be_i  in  4  store byte enables.
REQ-012 ls_addr_i  in  32  load/store address; ls_we_i/be/addr/wdata stable while ls_req_i high.
REQ-013 ls_wdata_i  in  32  store data.
REQ-014 ls_gnt_o  out  1  load/store request accepted by memory.
REQ-015 ls_rvalid_o  out  1  load/store response, one-cycle pulse; also pulses for stores.
REQ-016 ls_rdata_o  out  32  load data.
REQ-017 mem_req_o, mem_we_o, mem_be_o[3:0], mem_addr_o[31:0], mem_wdata_o[31:0]  out  shared memory request.
REQ-018 mem_gnt_i  in  1  memory accepts mem_req_o this cycle.
REQ-019 mem_rvalid_i  in  1  memory response; never earlier than the cycle after mem_gnt_i.
REQ-020 mem_rdata_i  in  32  memory read data, valid with mem_rvalid_i.

Function
REQ-021 FSM states SHALL be IDLE, REQ, RESP; at most one outstanding memory transaction.
REQ-022 IDLE: no request -> stay IDLE; any request -> select owner, register owner and its command fields, go REQ next cycle.
REQ-023 Selection: LSU wins when both request, unless starve_cnt == STARVE_LIMIT, then fetch wins; single requester always wins.
REQ-024 starve_cnt (4 bits) SHALL increment, saturating at STARVE_LIMIT, when LSU is selected with if_req_i high; clear when fetch selected or when LSU selected with if_req_i low.
REQ-025 REQ: mem_req_o = 1 with registered fields; mem_we_o = 0, mem_be_o = 4'hF, mem_wdata_o = 0 for fetch owner.
REQ-026 REQ: mem_gnt_i = 1 -> owner's gnt_o = 1 same cycle (combinational), next state RESP; otherwise hold all mem_* stable.
REQ-027 Latency: request sampled in IDLE at cycle N -> mem_req_o high at N+1; earliest gnt_o at N+1.
REQ-028 RESP: mem_req_o = 0; mem_rvalid_i = 1 -> owner's rvalid_o = 1 same cycle, owner's rdata_o = mem_rdata_i, next state IDLE.
REQ-029 Non-owner rvalid_o and gnt_o SHALL be 0 always; rdata_o SHALL be 0 whenever matching rvalid_o is 0.
REQ-030 mem_rvalid_i in IDLE or REQ, and mem_gnt_i outside REQ, SHALL be ignored.
REQ-031 Requests arriving during REQ/RESP SHALL wait; arbitration occurs only in IDLE (one idle bubble between transactions).
REQ-032 Requester dropping req before gnt is a protocol violation; behaviour undefined, no checking required.

Reset
REQ-033 rst_n_i low SHALL immediately force state IDLE, starve_cnt 0, owner fetch, registered fields 0, all outputs 0.
REQ-034 Reset during REQ or RESP SHALL abandon the transaction; no gnt_o/rvalid_o pulses for it after release.
REQ-035 First arbitration SHALL occur in the first rising edge with rst_n_i high.

Verification
REQ-036 Fetch only: if_req_i, addr 0x100, mem_gnt_i at N+1, mem_rvalid_i at N+3 data 0xDEADBEEF -> if_gnt_o at N+1, if_rvalid_o at N+3 with 0xDEADBEEF, ls_* outputs 0.
REQ-037 Store: ls_we_i 1, be 4'b0011, addr 0x2000, wdata 0x1234 -> mem_we_o 1, mem_be_o 3, fields held through 3 gnt-wait cycles, ls_rvalid_o on response.
REQ-038 Simultaneous requests continuously, STARVE_LIMIT=4, memory gnt/rvalid immediate -> grant order LSU x4, fetch, LSU x4, fetch.
REQ-039 mem_rvalid_i pulsed in IDLE and in REQ -> no rvalid_o pulse, state unchanged.
REQ-040 Reset asserted in RESP, then mem_rvalid_i after release -> no rvalid_o; next request served normally with starve_cnt 0.
REQ-041 New LSU request raised in RESP cycle -> not granted until after rvalid, mem_req_o rises two cycles after rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (fetch / load-store) arbiter onto one memory port
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,

  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,

  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // owner encoding: 1 = load/store unit, 0 = fetch
  logic [1:0]  state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        sel_ls;

  // Arbitration in IDLE, command capture, and transaction sequencing
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    // LSU has priority unless fetch has already lost LIMIT times in a row
    sel_ls       = ls_req_i && !(if_req_i && (starve_cnt_q == LIMIT));

    case (state_q)
      ST_IDLE: begin
        if (if_req_i || ls_req_i) begin
          state_d = ST_REQ;
          owner_d = sel_ls;
          if (sel_ls) begin
            we_d    = ls_we_i;
            be_d    = ls_be_i;
            addr_d  = ls_addr_i;
            wdata_d = ls_wdata_i;
            if (if_req_i) begin
              if (starve_cnt_q != LIMIT) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
              end
            end else begin
              starve_cnt_d = 4'd0;
            end
          end else begin
            we_d         = 1'b0;
            be_d         = 4'hF;
            addr_d       = if_addr_i;
            wdata_d      = 32'd0;
            starve_cnt_d = 4'd0;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_rvalid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory request and per-port handshake/response steering from current state
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 32'd0;
    if_gnt_o    = 1'b0;
    ls_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    ls_rvalid_o = 1'b0;
    if_rdata_o  = 32'd0;
    ls_rdata_o  = 32'd0;

    case (state_q)
      ST_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_be_o    = be_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (mem_gnt_i) begin
          ls_gnt_o = owner_q;
          if_gnt_o = !owner_q;
        end
      end
      ST_RESP: begin
        if (mem_rvalid_i) begin
          if (owner_q) begin
            ls_rvalid_o = 1'b1;
            ls_rdata_o  = mem_rdata_i;
          end else begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // State registers; reset abandons any transaction in flight
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= 4'd0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= 4'h0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule
